// File: rtl/rx_word_ctrl.sv
// Serial word receiver: start bit 1, seven data bits MSB first, optional even parity, stop bit 0.
// Define RX_PARITY_EN to compile in the parity state and its check.
module rx_word_ctrl #(
    parameter int ERR_W = 4
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             lock,
    input  logic             data_in,
    input  logic             bit_tick,
    output logic [6:0]       word,
    output logic             word_valid,
    output logic             busy,
    output logic [ERR_W-1:0] err_cnt,
    output logic [7:0]       led_1
);

`ifdef RX_PARITY_EN
    typedef enum logic [1:0] {HUNT, SHIFT, PAR, STOP} state_t;
`else
    typedef enum logic [1:0] {HUNT, SHIFT, STOP} state_t;
`endif

    state_t     state, state_nxt;
    logic [6:0] shreg;
    logic [2:0] bit_cnt;
    logic       err_flag;
    logic       frame_ok;
    logic       advance;

    assign advance = bit_tick && !lock;

`ifdef RX_PARITY_EN
    logic par_err;

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            par_err <= 1'b0;
        end else if (lock) begin
            par_err <= 1'b0;
        end else if (bit_tick) begin
            if (state == HUNT && data_in)
                par_err <= 1'b0;
            else if (state == PAR)
                par_err <= ^{shreg, data_in};
        end
    end

    assign frame_ok = !data_in && !par_err;
`else
    assign frame_ok = !data_in;
`endif

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset)
            state <= HUNT;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (lock) begin
            state_nxt = HUNT;
        end else if (bit_tick) begin
            unique case (state)
                HUNT:  if (data_in) state_nxt = SHIFT;
`ifdef RX_PARITY_EN
                SHIFT: if (bit_cnt == 3'd6) state_nxt = PAR;
                PAR:   state_nxt = STOP;
`else
                SHIFT: if (bit_cnt == 3'd6) state_nxt = STOP;
`endif
                STOP:  state_nxt = HUNT;
                default: state_nxt = HUNT;
            endcase
        end
    end

    always_comb begin
        busy  = (state != HUNT);
        led_1 = {err_flag, word};
    end

    // Datapath; word_valid is a registered pulse, so it is cleared every cycle by default.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            word       <= '0;
            word_valid <= 1'b0;
            err_flag   <= 1'b0;
            err_cnt    <= '0;
        end else begin
            word_valid <= 1'b0;
            if (lock) begin
                shreg   <= '0;
                bit_cnt <= '0;
            end else if (advance) begin
                case (state)
                    HUNT: begin
                        if (data_in) begin
                            shreg   <= '0;
                            bit_cnt <= '0;
                        end
                    end
                    SHIFT: begin
                        shreg   <= {shreg[5:0], data_in};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    STOP: begin
                        if (frame_ok) begin
                            word       <= shreg;
                            word_valid <= 1'b1;
                            err_flag   <= 1'b0;
                        end else begin
                            err_flag <= 1'b1;
                            if (err_cnt != '1)
                                err_cnt <= err_cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
